// File: rtl/div_issue_ctrl_if.sv
// Bundles the signals between the divide sequencer and its surroundings.
//
// The slave modport is the sequencer's view. The master modport is the
// environment's view: the EX pipeline and the HI/LO divider wrapper together.
//   Pipeline -> ctrl : flush, start, is_signed, dividend, divisor
//   ctrl -> pipeline : stall, done, hi_out (remainder), lo_out (quotient)
//   ctrl -> divider  : div_a (divisor), div_b (dividend), div_signed
//   divider -> ctrl  : div_hi (remainder), div_lo (quotient)
interface div_issue_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             flush;
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic [WIDTH-1:0] div_a;
  logic [WIDTH-1:0] div_b;
  logic             div_signed;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;

  modport master (
    output flush, start, is_signed, dividend, divisor, div_hi, div_lo,
    input  stall, done, hi_out, lo_out, div_a, div_b, div_signed
  );

  modport slave (
    input  flush, start, is_signed, dividend, divisor, div_hi, div_lo,
    output stall, done, hi_out, lo_out, div_a, div_b, div_signed
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// Multi-cycle divide sequencer sitting in EX in front of the HI/LO divider.
//
// It accepts a DIV/DIVU request and latches the operands onto the divider
// inputs. It then waits a fixed LATENCY cycles with the pipeline stalled,
// captures quotient (lo) and remainder (hi), and pulses done for one cycle.
// A zero divisor short-circuits: hi = dividend, lo = all ones.
//
// Ports:
//   clk    : clock, rising edge
//   resetn : synchronous active-low reset
//   bus    : div_issue_ctrl_if.slave (pipeline handshake and divider link)
module div_issue_ctrl #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 37
) (
  input logic             clk,
  input logic             resetn,
  div_issue_ctrl_if.slave bus
);

  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.flush) begin
          a_d   = bus.divisor;
          b_d   = bus.dividend;
          sgn_d = bus.is_signed;
          if (bus.divisor != '0) begin
            cnt_d   = CntW'(LATENCY - 1);
            state_d = StWait;
          end else begin
            // Divide by zero never reaches the divider.
            hi_d    = bus.dividend;
            lo_d    = '1;
            done_d  = 1'b1;
            state_d = StDone;
          end
        end
      end
      StWait: begin
        if (bus.flush) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          hi_d    = bus.div_hi;
          lo_d    = bus.div_lo;
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        // start here is the finished instruction leaving EX, never a re-issue.
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
    end
  end

  // Stall is low in DONE so the pipeline advances in the same cycle as done.
  assign bus.stall      = ((state_q == StIdle) && bus.start && !bus.flush) ||
                          (state_q == StWait);
  assign bus.done       = done_q;
  assign bus.hi_out     = hi_q;
  assign bus.lo_out     = lo_q;
  assign bus.div_a      = a_q;
  assign bus.div_b      = b_q;
  assign bus.div_signed = sgn_q;

endmodule
